// File: rtl/lcd_port_arbiter_if.sv
// lcd_port_arbiter_if: requester-side and LCD-side signals of the shared LCD write port.
interface lcd_port_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ-1:0]        wr_en;
    logic [NUM_REQ-1:0]        wr_rs;
    logic [NUM_REQ*DATA_W-1:0] wr_data;
    logic                      lcd_busy;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        wr_ack;
    logic                      lcd_we;
    logic                      lcd_rs;
    logic [DATA_W-1:0]         lcd_data;
    logic [1:0]                owner;
    logic                      hold_timeout;

    modport slave (
        input  req, wr_en, wr_rs, wr_data, lcd_busy,
        output gnt, wr_ack, lcd_we, lcd_rs, lcd_data, owner, hold_timeout
    );

    modport master (
        output req, wr_en, wr_rs, wr_data, lcd_busy,
        input  gnt, wr_ack, lcd_we, lcd_rs, lcd_data, owner, hold_timeout
    );
endinterface

// File: rtl/lcd_port_arbiter.sv
// lcd_port_arbiter: round-robin, lock-until-release sharing of one LCD write port with a hold watchdog.
module lcd_port_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int DATA_W   = 8,
    parameter int HOLD_MAX = 255
) (
    input logic                 clk,
    input logic                 rst,
    lcd_port_arbiter_if.slave   bus
);
    typedef enum logic {IDLE, OWN} state_t;

    state_t              state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d, ack_q, ack_d;
    logic [1:0]          owner_q, owner_d, ptr_q, ptr_d, win, idx, nxt;
    logic [7:0]          hold_q, hold_d;
    logic                we_q, we_d, rs_q, rs_d, to_q, to_d, accept;
    logic [DATA_W-1:0]   data_q, data_d;

    assign accept = (state_q == OWN) && bus.wr_en[owner_q] && !bus.lcd_busy;
    assign nxt    = 2'((int'(owner_q) + 1) % NUM_REQ);

    // Scan downward so the last hit is the first requester at or after the pointer.
    always_comb begin
        win = ptr_q;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = 2'((int'(ptr_q) + k) % NUM_REQ);
            if (bus.req[idx]) win = idx;
        end
    end

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        to_d    = 1'b0;
        we_d    = accept;
        ack_d   = accept ? gnt_q : '0;
        rs_d    = accept ? bus.wr_rs[owner_q] : rs_q;
        data_d  = accept ? bus.wr_data[owner_q*DATA_W +: DATA_W] : data_q;
        if (state_q == IDLE) begin
            if (|bus.req) begin
                state_d = OWN;
                gnt_d   = NUM_REQ'(1) << win;
                owner_d = win;
                hold_d  = '0;
            end
        end else if (!bus.req[owner_q]) begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = nxt;
        end else if (accept) begin
            hold_d = '0;
        end else if (hold_q == 8'(HOLD_MAX)) begin
            state_d = IDLE;
            gnt_d   = '0;
            ptr_d   = nxt;
            to_d    = 1'b1;
        end else begin
            hold_d = hold_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            gnt_q   <= '0;
            owner_q <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            to_q    <= 1'b0;
            we_q    <= 1'b0;
            ack_q   <= '0;
            rs_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            to_q    <= to_d;
            we_q    <= we_d;
            ack_q   <= ack_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    assign bus.gnt          = gnt_q;
    assign bus.wr_ack       = ack_q;
    assign bus.lcd_we       = we_q;
    assign bus.lcd_rs       = rs_q;
    assign bus.lcd_data     = data_q;
    assign bus.owner        = owner_q;
    assign bus.hold_timeout = to_q;
endmodule

// File: tb/tb_lcd_port_arbiter.sv
// tb_lcd_port_arbiter: directed checks of arbitration, forwarding, back-pressure, watchdog and reset.
module tb_lcd_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    lcd_port_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) a ();
    lcd_port_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) w ();

    lcd_port_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_MAX(255)) dut_a (.clk(clk), .rst(rst), .bus(a));
    lcd_port_arbiter #(.NUM_REQ(4), .DATA_W(8), .HOLD_MAX(4))   dut_w (.clk(clk), .rst(rst), .bus(w));

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        a.req = '0; a.wr_en = '0; a.wr_rs = '0; a.wr_data = '0; a.lcd_busy = 1'b0;
        w.req = '0; w.wr_en = '0; w.wr_rs = '0; w.wr_data = '0; w.lcd_busy = 1'b0;
        step();
        step();
        chk("rst_gnt", 32'(a.gnt), 32'h0);
        chk("rst_owner", 32'(a.owner), 32'h0);
        chk("rst_we", 32'(a.lcd_we), 32'h0);
        chk("rst_data", 32'(a.lcd_data), 32'h0);
        chk("rst_rs", 32'(a.lcd_rs), 32'h0);
        chk("rst_ack", 32'(a.wr_ack), 32'h0);
        chk("rst_to", 32'(w.hold_timeout), 32'h0);
        rst = 1'b1;
        step();

        // round robin with every requester asking: 0,1,2,3,0
        a.req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            int e;
            e = n % 4;
            step();
            chk("rr_gnt", 32'(a.gnt), 32'(4'b0001 << e));
            chk("rr_owner", 32'(a.owner), 32'(e));
            a.wr_en[e] = 1'b1;
            a.wr_data[e*8 +: 8] = 8'(8'h50 + e);
            step();
            chk("rr_we", 32'(a.lcd_we), 32'h1);
            chk("rr_data", 32'(a.lcd_data), 32'(8'h50 + e));
            chk("rr_ack", 32'(a.wr_ack), 32'(4'b0001 << e));
            a.wr_en[e] = 1'b0;
            a.req[e] = 1'b0;
            step();
            chk("rr_gap", 32'(a.gnt), 32'h0);
            a.req[e] = 1'b1;
        end
        a.req = '0;
        step();

        // single requester write
        a.req = 4'b0010;
        step();
        chk("s_gnt", 32'(a.gnt), 32'h2);
        chk("s_owner", 32'(a.owner), 32'h1);
        a.wr_en[1] = 1'b1; a.wr_rs[1] = 1'b1; a.wr_data[15:8] = 8'h41;
        step();
        chk("s_we", 32'(a.lcd_we), 32'h1);
        chk("s_data", 32'(a.lcd_data), 32'h41);
        chk("s_rs", 32'(a.lcd_rs), 32'h1);
        chk("s_ack", 32'(a.wr_ack), 32'h2);
        a.wr_en[1] = 1'b0; a.wr_rs[1] = 1'b0;
        step();
        chk("s_we_off", 32'(a.lcd_we), 32'h0);
        chk("s_data_hold", 32'(a.lcd_data), 32'h41);
        chk("s_rs_hold", 32'(a.lcd_rs), 32'h1);
        a.req = '0;
        step();
        chk("s_rel", 32'(a.gnt), 32'h0);

        // back-pressure on owner 2
        a.req = 4'b0100;
        step();
        chk("bp_gnt", 32'(a.gnt), 32'h4);
        a.lcd_busy = 1'b1; a.wr_en[2] = 1'b1; a.wr_data[23:16] = 8'h30;
        for (int n = 0; n < 5; n++) begin
            step();
            chk("bp_we_busy", 32'(a.lcd_we), 32'h0);
            chk("bp_ack_busy", 32'(a.wr_ack), 32'h0);
        end
        a.lcd_busy = 1'b0;
        step();
        chk("bp_we", 32'(a.lcd_we), 32'h1);
        chk("bp_data", 32'(a.lcd_data), 32'h30);
        chk("bp_ack", 32'(a.wr_ack), 32'h4);
        a.wr_en[2] = 1'b0;
        step();
        chk("bp_single", 32'(a.lcd_we), 32'h0);
        a.req = '0;
        step();

        // non-owner strobe ignored
        a.req = 4'b0001;
        step();
        chk("no_gnt", 32'(a.gnt), 32'h1);
        a.wr_en[3] = 1'b1; a.wr_data[31:24] = 8'hFF;
        step();
        chk("no_we", 32'(a.lcd_we), 32'h0);
        chk("no_ack", 32'(a.wr_ack), 32'h0);
        step();
        chk("no_data", 32'(a.lcd_data), 32'h30);
        a.wr_en[3] = 1'b0; a.req = '0;
        step();

        // watchdog on the HOLD_MAX=4 instance
        w.req = 4'b1000;
        step();
        chk("wd_gnt", 32'(w.gnt), 32'h8);
        for (int n = 1; n <= 4; n++) begin
            step();
            chk("wd_hold", 32'({w.gnt, 3'b0, w.hold_timeout}), 32'h80);
        end
        step();
        chk("wd_revoke", 32'(w.gnt), 32'h0);
        chk("wd_to", 32'(w.hold_timeout), 32'h1);
        w.req = 4'b1001;
        step();
        chk("wd_to_pulse", 32'(w.hold_timeout), 32'h0);
        chk("wd_next", 32'(w.gnt), 32'h1);
        w.req = '0;

        // reset in the middle of a write
        a.req = 4'b0100;
        step();
        chk("rm_gnt", 32'(a.gnt), 32'h4);
        a.wr_en[2] = 1'b1; a.wr_data[23:16] = 8'h77;
        step();
        chk("rm_we", 32'(a.lcd_we), 32'h1);
        rst = 1'b0;
        a.wr_en[2] = 1'b0;
        #1;
        chk("rm_we_rst", 32'(a.lcd_we), 32'h0);
        chk("rm_gnt_rst", 32'(a.gnt), 32'h0);
        chk("rm_owner_rst", 32'(a.owner), 32'h0);
        step();
        chk("rm_we_hold", 32'(a.lcd_we), 32'h0);
        rst = 1'b1;
        step();
        chk("rm_regnt", 32'(a.gnt), 32'h4);
        chk("rm_owner", 32'(a.owner), 32'h2);
        a.req = '0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/lcd_port_arbiter.md
Name: lcd_port_arbiter

Overview:
- Shares the single character-LCD write port between up to four requesters: process control, access control, game, scoreboard.
- Round-robin arbitration with a lock-until-release grant, so one owner can write a whole message without interleaving.
- Registered write forwarding with back-pressure from the LCD driver's busy flag.
- Hold watchdog reclaims the port from a requester that stalls.

Parameters:
- NUM_REQ, 4, number of requesters; index 0 = process control, 1 = access control, 2 = game, 3 = scoreboard.
- DATA_W, 8, LCD data byte width.
- HOLD_MAX, 255, maximum consecutive idle cycles an owner may hold the port without a write; must be ≥1 and ≤255.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- req  input  NUM_REQ  per-requester port request, level.
- wr_en  input  NUM_REQ  per-requester write strobe.
- wr_rs  input  NUM_REQ  per-requester register select (0 = command, 1 = data).
- wr_data  input  NUM_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- lcd_busy  input  1  LCD driver cannot accept a write this cycle.
- gnt  output  NUM_REQ  one-hot grant, registered.
- wr_ack  output  NUM_REQ  one-cycle pulse to the owner when its write was accepted.
- lcd_we  output  1  one-cycle write pulse to the LCD driver.
- lcd_rs  output  1  register select forwarded with lcd_we.
- lcd_data  output  DATA_W  byte forwarded with lcd_we.
- owner  output  2  index of the current owner; valid while gnt != 0.
- hold_timeout  output  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (asynchronous, rst=0):
  - State = IDLE.
  - gnt, wr_ack, lcd_we, lcd_rs, lcd_data, owner, hold_timeout = 0.
  - Round-robin pointer = 0; hold counter = 0.
  - Reset mid-transfer drops the grant and any pending write immediately; no lcd_we is emitted after rst asserts.
- States: IDLE, OWN.
- IDLE:
  - If req != 0, select the first asserted req scanning from the pointer upward, with wrap-around.
  - Next cycle: gnt = one-hot of the winner, owner = winner, state = OWN, hold counter = 0.
  - Grant latency is exactly 1 cycle from the first sampled req.
- OWN, write acceptance:
  - A write is accepted on a cycle where wr_en[owner]=1 and lcd_busy=0.
  - The following cycle: lcd_we=1, lcd_rs/lcd_data = values sampled with the strobe, and wr_ack[owner]=1.
  - Maximum throughput is one write per cycle.
  - While lcd_busy=1, no acceptance occurs; the requester holds wr_en and its data.
  - wr_en from any non-owner is ignored with no ack.
- OWN, hold counter:
  - Cleared on each accepted write; incremented otherwise.
  - When it reaches HOLD_MAX with no acceptance on that cycle: revoke the grant.
  - On revocation, the next cycle has gnt=0, hold_timeout=1 and state = IDLE.
- OWN, release:
  - req[owner]=0 sampled → next cycle gnt=0, state = IDLE.
  - A write accepted on the same cycle as the req drop is still forwarded and acked.
- Fairness:
  - On leaving OWN (release or timeout), pointer = owner+1 mod NUM_REQ.
  - IDLE lasts at least 1 cycle between grants, so gnt is never re-issued back-to-back without a zero cycle.
- lcd_rs and lcd_data hold their last values when lcd_we=0.
- Unused requester indices (NUM_REQ<4) are tied off and never granted.

Test Plan:
- Single requester: req[1]=1 at cycle 0 → gnt=4'b0010 and owner=1 at cycle 1; wr_en[1] with data 8'h41, rs=1, lcd_busy=0 at cycle 2 → lcd_we=1, lcd_data=8'h41, lcd_rs=1, wr_ack[1]=1 at cycle 3.
- Round-robin order: req=4'b1111 held, each owner writes one byte and then drops req → grants issue in order 0,1,2,3,0 with one gnt=0 cycle between each.
- Back-pressure: owner 2 strobes 8'h30 while lcd_busy=1 for 5 cycles → no lcd_we and no wr_ack during busy; one lcd_we with 8'h30 on the cycle after busy drops.
- Non-owner write: owner 0 granted, wr_en[3]=1 with 8'hFF → no lcd_we, no wr_ack[3]; lcd_data unchanged.
- Watchdog: HOLD_MAX=4, owner 3 holds req with no writes → hold_timeout pulses and gnt=0 five cycles after the grant; next grant favours index 0 if it is requesting.
- Reset mid-write: rst=0 on the cycle after an accepted write → lcd_we, gnt and owner are 0 immediately; after rst=1 with req[2]=1, first grant is to 2 and the pointer starts from 0.
